// File: rtl/sum_result_fifo.sv
// sum_result_fifo: show-ahead FIFO buffering {carry, sum} results from an adder.
// Pushes that arrive while the FIFO is full with no pop are dropped and counted
// in a saturating overflow counter. When full, a push and a pop in the same
// cycle are both accepted.
// Optional feature: define SUM_CARRY_STAT_EN to add Carry_cnt. This is a
// saturating count of accepted pushes whose Sum_carry is 1.
module sum_result_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    Sum_result,
  input  logic          Sum_carry,
  input  logic          Data_ready,
  input  logic          Out_ready,
  input  logic          Clr_overflow,
  output logic          Out_valid,
  output logic [7:0]    Out_sum,
  output logic          Out_carry,
  output logic          Fifo_full,
  output logic          Fifo_empty,
  output logic [AW:0]   Fifo_count,
  output logic [7:0]    Overflow_cnt
`ifdef SUM_CARRY_STAT_EN
  ,
  output logic [7:0]    Carry_cnt
`endif
);

  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE_C = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

  logic [8:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [7:0]    ovf_cnt_r;

  logic          full_s;
  logic          empty_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic [8:0]    head_s;

  // Decode status and handshake qualifiers from the occupancy count.
  always_comb begin
    full_s  = (count_r == DEPTH_C);
    empty_s = (count_r == {(AW+1){1'b0}});
    pop_s   = !empty_s && Out_ready;
    push_s  = Data_ready && (!full_s || pop_s);
    drop_s  = Data_ready && full_s && !pop_s;
    head_s  = mem_r[rd_ptr_r];
  end

  assign Out_valid    = !empty_s;
  assign Out_sum      = head_s[7:0];
  assign Out_carry    = head_s[8];
  assign Fifo_full    = full_s;
  assign Fifo_empty   = empty_s;
  assign Fifo_count   = count_r;
  assign Overflow_cnt = ovf_cnt_r;

  // Write accepted entries into storage; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_r[wr_ptr_r] <= {Sum_carry, Sum_result};
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Advance pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Count dropped pushes, saturating at 255; a clear wins over a drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_cnt_r <= 8'd0;
    end else if (Clr_overflow) begin
      ovf_cnt_r <= 8'd0;
    end else if (drop_s && (ovf_cnt_r != 8'hFF)) begin
      ovf_cnt_r <= ovf_cnt_r + 8'd1;
    end else begin
      ovf_cnt_r <= ovf_cnt_r;
    end
  end

`ifdef SUM_CARRY_STAT_EN
  logic [7:0] carry_cnt_r;

  assign Carry_cnt = carry_cnt_r;

  // Count accepted pushes carrying a set carry bit, saturating at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_cnt_r <= 8'd0;
    end else if (Clr_overflow) begin
      carry_cnt_r <= 8'd0;
    end else if (push_s && Sum_carry && (carry_cnt_r != 8'hFF)) begin
      carry_cnt_r <= carry_cnt_r + 8'd1;
    end else begin
      carry_cnt_r <= carry_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_sum_result_fifo.sv
// Self-checking bench for sum_result_fifo.
// A queue-based reference model predicts every output after each clock.
module tb_sum_result_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          reset;
  logic [7:0]    Sum_result;
  logic          Sum_carry;
  logic          Data_ready;
  logic          Out_ready;
  logic          Clr_overflow;
  logic          Out_valid;
  logic [7:0]    Out_sum;
  logic          Out_carry;
  logic          Fifo_full;
  logic          Fifo_empty;
  logic [AW:0]   Fifo_count;
  logic [7:0]    Overflow_cnt;
`ifdef SUM_CARRY_STAT_EN
  logic [7:0]    Carry_cnt;
`endif

  sum_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .Sum_result   (Sum_result),
    .Sum_carry    (Sum_carry),
    .Data_ready   (Data_ready),
    .Out_ready    (Out_ready),
    .Clr_overflow (Clr_overflow),
    .Out_valid    (Out_valid),
    .Out_sum      (Out_sum),
    .Out_carry    (Out_carry),
    .Fifo_full    (Fifo_full),
    .Fifo_empty   (Fifo_empty),
    .Fifo_count   (Fifo_count),
    .Overflow_cnt (Overflow_cnt)
`ifdef SUM_CARRY_STAT_EN
    ,
    .Carry_cnt    (Carry_cnt)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [8:0] model_q [$];
  int         model_ovf = 0;
  int         model_carry = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare every DUT output with the reference model.
  task automatic check_all(input string tag);
    check_value({tag, ".valid"}, 32'(Out_valid), 32'(model_q.size() != 0));
    check_value({tag, ".count"}, 32'(Fifo_count), 32'(model_q.size()));
    check_value({tag, ".full"},  32'(Fifo_full),  32'(model_q.size() == DEPTH));
    check_value({tag, ".empty"}, 32'(Fifo_empty), 32'(model_q.size() == 0));
    check_value({tag, ".ovf"},   32'(Overflow_cnt), 32'(model_ovf));
    if (model_q.size() != 0) begin
      check_value({tag, ".sum"},   32'(Out_sum),   32'(model_q[0][7:0]));
      check_value({tag, ".carry"}, 32'(Out_carry), 32'(model_q[0][8]));
    end
`ifdef SUM_CARRY_STAT_EN
    check_value({tag, ".ccnt"}, 32'(Carry_cnt), 32'(model_carry));
`endif
  endtask

  // Apply one cycle of inputs, update the model, clock, then check.
  task automatic cycle(input string tag, input logic rst, input logic dr,
                       input logic [7:0] s, input logic c, input logic ordy,
                       input logic clr);
    bit full;
    bit pop;
    bit push;
    reset        = rst;
    Data_ready   = dr;
    Sum_result   = s;
    Sum_carry    = c;
    Out_ready    = ordy;
    Clr_overflow = clr;
    if (rst) begin
      model_q.delete();
      model_ovf   = 0;
      model_carry = 0;
    end else begin
      full = (model_q.size() == DEPTH);
      pop  = (model_q.size() != 0) && ordy;
      push = dr && (!full || pop);
      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back({c, s});
      if (clr) model_ovf = 0;
      else if (dr && full && !pop && model_ovf < 255) model_ovf++;
      if (clr) model_carry = 0;
      else if (push && c && model_carry < 255) model_carry++;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2; i++) cycle(tag, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic fill(input string tag, input int base);
    for (int i = 0; i < DEPTH; i++)
      cycle(tag, 1'b0, 1'b1, 8'(base + i), 1'(i % 2), 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; Data_ready = 1'b0; Sum_result = 8'h00; Sum_carry = 1'b0;
    Out_ready = 1'b0; Clr_overflow = 1'b0;

    // Reset state.
    cycle("reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle("reset2", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Empty-pop has no effect; single push visible next cycle.
    cycle("empty_pop", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle("push8", 1'b0, 1'b1, 8'd8, 1'b0, 1'b0, 1'b0);
    cycle("hold8", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drain("drain8");

    // Fill 1..8, ninth push dropped, drain in order.
    for (int i = 1; i <= DEPTH; i++) cycle("fill18", 1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    cycle("drop9", 1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    drain("drain18");

    // Full with simultaneous push and pop.
    fill("fill_aa", 8'h10);
    cycle("full_pp", 1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    drain("drain_aa");

    // Interleaved pushes and pops across the pointer wrap.
    for (int i = 0; i < 20; i++)
      cycle("wrap", 1'b0, 1'b1, 8'(8'h40 + i), 1'(i % 3 == 0), 1'(i % 2), 1'b0);
    drain("drain_wrap");

    // Overflow saturation and clear overriding a drop.
    fill("fill_ovf", 8'h80);
    for (int i = 0; i < 300; i++) cycle("ovf_sat", 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    check_value("ovf_is_255", 32'(Overflow_cnt), 32'd255);
    cycle("ovf_clr", 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    drain("drain_ovf");

    // Reset with five entries held.
    for (int i = 0; i < 5; i++) cycle("five", 1'b0, 1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 1'b0);
    cycle("mid_reset", 1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle("carry3", 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef SUM_CARRY_STAT_EN
    check_value("carry_is_3", 32'(Carry_cnt), 32'd3);
`endif
    drain("drain_carry");

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      cycle("rand", 1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 99) < 60),
            8'($urandom), 1'($urandom), 1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 99) < 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
